// File: rtl/mem_access_unit.sv
// Memory access stage between the multi-cycle controller and a req/ack
// memory bus. Issues one registered bus request per controller memory
// state, stalls the controller until the access finishes, then releases
// it for exactly one cycle (HOLD) so it can advance.
//
// state  | meaning
// IDLE   | waiting for a read/write strobe from the controller
// ACCESS | request on the bus, waiting for bus_ack or timeout
// HOLD   | one-cycle release; stale strobes from the old state are ignored
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        ir_write,
    input  logic        iord,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        addr_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             op_is_read;
    logic             ir_write_lat;

    logic        req;
    logic [31:0] addr;
    logic        aligned;
    logic        at_limit;
    logic        issue;
    logic        misaligned;
    logic        complete;
    logic        abort;

    // Both strobes high is a controller conflict and counts as no request.
    assign req      = mem_read ^ mem_write;
    assign addr     = iord ? alu_out : pc;
    assign aligned  = (addr[1:0] == 2'b00);
    assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, stall and per-cycle action strobes.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        issue      = 1'b0;
        misaligned = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (aligned) begin
                        stall      = 1'b1;
                        issue      = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        misaligned = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                // An ack on the final allowed cycle still wins over the abort.
                if (bus_ack) begin
                    complete   = 1'b1;
                    state_next = HOLD;
                end else if (at_limit) begin
                    abort      = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // The controller must never see a stall while this unit is in reset.
        if (reset) begin
            stall = 1'b0;
        end
    end

    // Bus request registers, wait counter, IR/MDR and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_rd       <= 1'b0;
            bus_wr       <= 1'b0;
            op_is_read   <= 1'b0;
            ir_write_lat <= 1'b0;
            cnt          <= '0;
            instr        <= '0;
            mdr          <= '0;
            addr_err     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (issue) begin
                bus_addr     <= addr;
                bus_wdata    <= write_data;
                bus_rd       <= mem_read;
                bus_wr       <= mem_write;
                op_is_read   <= mem_read;
                ir_write_lat <= ir_write;
                cnt          <= '0;
            end
            if (state == ACCESS) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (complete || abort) begin
                bus_rd <= 1'b0;
                bus_wr <= 1'b0;
            end
            if (complete && op_is_read) begin
                mdr <= bus_rdata;
                if (ir_write_lat) begin
                    instr <= bus_rdata;
                end
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
            if (misaligned) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a directed table of controller
// transactions, an asynchronous reset in the middle of an access, then
// randomized transactions checked against a transaction-level model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        iord;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        stall;
    logic        addr_err;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .iord(iord),
        .pc(pc), .alu_out(alu_out), .write_data(write_data),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .instr(instr), .mdr(mdr), .stall(stall),
        .addr_err(addr_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One controller memory state: inputs, ack timing (d = ACCESS cycle that
    // carries bus_ack, 0 = never) and the expected result afterwards.
    typedef struct {
        logic        rd, wr, irw, iord;
        logic [31:0] pc, alu, wd, rdata;
        int          d;
        logic [31:0] e_instr, e_mdr;
        logic        e_aerr, e_terr;
        int          e_stall;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        int          stall_cnt;
        int          acc;
        logic [31:0] addr, wdata;
        logic        rd, wr;
        logic        unstable;
        logic        done;
    } obs_t;

    logic [31:0] m_instr, m_mdr;
    logic        m_aerr, m_terr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome of one controller memory state.
    task automatic model(inout vec_t v);
        logic [31:0] a;
        bit          acked;
        a         = v.iord ? v.alu : v.pc;
        v.e_addr  = a;
        v.e_stall = 0;
        if (v.rd != v.wr) begin
            if (a[1:0] != 2'b00) begin
                m_aerr = 1'b1;
            end else begin
                acked     = (v.d >= 1) && (v.d <= TO);
                v.e_stall = 1 + (acked ? v.d : TO);
                if (!acked) begin
                    m_terr = 1'b1;
                end else if (v.rd) begin
                    m_mdr = v.rdata;
                    if (v.irw) m_instr = v.rdata;
                end
            end
        end
        v.e_instr = m_instr;
        v.e_mdr   = m_mdr;
        v.e_aerr  = m_aerr;
        v.e_terr  = m_terr;
    endtask

    // Acts as controller and memory for one controller state: holds strobes
    // until stall is seen low, answers the bus request after v.d cycles.
    task automatic run_txn(input vec_t v, input bit noise, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; ir_write = v.irw; iord = v.iord;
        pc = v.pc; alu_out = v.alu; write_data = v.wd; bus_ack = 1'b0;
        for (int cyc = 0; cyc < 64 && !o.done; cyc++) begin
            #1;
            if (bus_rd || bus_wr) begin
                o.acc++;
                if (o.acc == 1) begin
                    o.addr = bus_addr; o.wdata = bus_wdata; o.rd = bus_rd; o.wr = bus_wr;
                end else if (bus_addr !== o.addr || bus_wdata !== o.wdata ||
                             bus_rd !== o.rd || bus_wr !== o.wr) begin
                    o.unstable = 1'b1;
                end
                bus_ack   = (o.acc == v.d);
                bus_rdata = bus_ack ? v.rdata : $urandom;
            end else begin
                bus_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus_rdata = $urandom;
            end
            if (stall) o.stall_cnt++;
            else       o.done = 1'b1;
            if (noise && cyc > 0) begin
                pc = $urandom; alu_out = $urandom; write_data = $urandom;
                ir_write = 1'($urandom_range(0, 1)); iord = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t v, input obs_t o);
        int exp_acc;
        exp_acc = (v.e_stall > 0) ? v.e_stall - 1 : 0;
        #1;
        chk({tag, ".done"},        o.done, 1'b1);
        chk({tag, ".stall_cycles"}, o.stall_cnt, v.e_stall);
        chk({tag, ".bus_cycles"},  o.acc, exp_acc);
        if (o.acc > 0) begin
            chk({tag, ".bus_addr"},  o.addr, v.e_addr);
            chk({tag, ".bus_wdata"}, o.wdata, v.wd);
            chk({tag, ".bus_rd"},    o.rd, v.rd);
            chk({tag, ".bus_wr"},    o.wr, v.wr);
        end
        chk({tag, ".bus_stable"},  o.unstable, 1'b0);
        chk({tag, ".bus_idle"},    bus_rd | bus_wr, 1'b0);
        chk({tag, ".instr"},       instr, v.e_instr);
        chk({tag, ".mdr"},         mdr, v.e_mdr);
        chk({tag, ".addr_err"},    addr_err, v.e_aerr);
        chk({tag, ".timeout_err"}, timeout_err, v.e_terr);
        @(negedge clk);
    endtask

    vec_t vecs[8];
    vec_t rv;
    obs_t ob;

    initial begin
        //            rd    wr    irw   iord  pc            alu           wd            rdata         d  e_instr       e_mdr         aerr  terr  stall addr
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00400004, 32'h0,        32'h0,        32'h8C080004, 1, 32'h8C080004, 32'h8C080004, 1'b0, 1'b0, 2, 32'h00400004};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00400008, 32'h10010008, 32'h0,        32'hDEADBEEF, 3, 32'h8C080004, 32'hDEADBEEF, 1'b0, 1'b0, 4, 32'h10010008};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0040000C, 32'h10010010, 32'h12345678, 32'hFFFFFFFF, 1, 32'h8C080004, 32'hDEADBEEF, 1'b0, 1'b0, 2, 32'h10010010};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00400010, 32'h10010002, 32'h0,        32'h11111111, 1, 32'h8C080004, 32'hDEADBEEF, 1'b1, 1'b0, 0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00400014, 32'h10010020, 32'h55555555, 32'h22222222, 1, 32'h8C080004, 32'hDEADBEEF, 1'b1, 1'b0, 0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00400018, 32'h20000000, 32'h0,        32'h0BADC0DE, 4, 32'h8C080004, 32'h0BADC0DE, 1'b1, 1'b0, 5, 32'h20000000};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000100, 32'h0,        32'h0,        32'h33333333, 0, 32'h8C080004, 32'h0BADC0DE, 1'b1, 1'b1, 5, 32'h00000100};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000104, 32'h0,        32'h0,        32'hCAFEF00D, 2, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1, 3, 32'h00000104};

        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; ir_write = 1'b0; iord = 1'b0;
        pc = 32'h8; alu_out = 32'h0; write_data = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #2;
        chk("reset.stall_forced_low", stall, 1'b0);
        #20;
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset.bus_addr", bus_addr, 32'h0);
        chk("reset.bus_rd_wr", {bus_rd, bus_wr}, 2'b00);
        chk("reset.instr", instr, 32'h0);
        chk("reset.mdr", mdr, 32'h0);
        chk("reset.flags", {addr_err, timeout_err}, 2'b00);
        chk("reset.stall", stall, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], 1'b0, ob);
            compare($sformatf("vec%0d", i), vecs[i], ob);
        end

        // Asynchronous reset between edges while a read is on the bus.
        @(negedge clk);
        pc = 32'h40; iord = 1'b0; mem_read = 1'b1; ir_write = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid.bus_rd_before", bus_rd, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid.bus_rd", bus_rd, 1'b0);
        chk("rst_mid.stall", stall, 1'b0);
        chk("rst_mid.bus_addr", bus_addr, 32'h0);
        chk("rst_mid.bus_wdata", bus_wdata, 32'h0);
        chk("rst_mid.instr", instr, 32'h0);
        chk("rst_mid.mdr", mdr, 32'h0);
        chk("rst_mid.flags", {addr_err, timeout_err}, 2'b00);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("rst_mid.late_ack_mdr", mdr, 32'h0);
        chk("rst_mid.late_ack_instr", instr, 32'h0);
        chk("rst_mid.late_ack_stall", stall, 1'b0);

        m_instr = 32'h0; m_mdr = 32'h0; m_aerr = 1'b0; m_terr = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int op;
            op       = $urandom_range(0, 7);
            rv       = '{default: 0};
            rv.rd    = (op < 4) || (op == 7);
            rv.wr    = (op >= 4);
            rv.irw   = 1'($urandom_range(0, 1));
            rv.iord  = 1'($urandom_range(0, 1));
            rv.pc    = $urandom;
            rv.alu   = $urandom;
            if ($urandom_range(0, 3) != 0) rv.pc[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rv.alu[1:0] = 2'b00;
            rv.wd    = $urandom;
            rv.rdata = $urandom;
            rv.d     = $urandom_range(0, 6);
            model(rv);
            run_txn(rv, 1'b1, ob);
            compare($sformatf("rand%0d", i), rv, ob);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
